// File: rtl/wta_pkg.sv
// Shared types and default constants for the winner-take-all readout.
package wta_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } wta_state_t;

    localparam int DEF_N_OUT      = 10;
    localparam int DEF_CNT_WIDTH  = 12;
    localparam int DEF_TIMEOUT    = 4000;
    localparam int DEF_CLR_CYCLES = 2;

endpackage

// File: rtl/first_one_enc.sv
// Lowest-set-index encoder with any/multi-hot flags; purely combinational, no backpressure.
module first_one_enc #(
    parameter int N  = 10,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec_i,
    output logic          any_o,
    output logic          multi_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

    assign any_o   = |vec_i;
    assign multi_o = |(vec_i & (vec_i - N'(1)));

endmodule

// File: rtl/wta_readout.sv
// Runs one classification: clears the neuron array, times the first spike, holds the result.
// Result appears one cycle after detection/timeout and is held until result_ack.
module wta_readout
    import wta_pkg::*;
#(
    parameter int N_OUT      = DEF_N_OUT,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_OUT-1:0]         neuron_outs,
    output logic                     neuron_rst,
    output logic                     busy,
    output logic                     result_valid,
    input  logic                     result_ack,
    output logic [$clog2(N_OUT)-1:0] winner,
    output logic [CNT_WIDTH-1:0]     latency,
    output logic                     tie,
    output logic                     timeout
);

    localparam int IW = $clog2(N_OUT);

    wta_state_t           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 neuron_rst_q;
    logic                 busy_q;
    logic                 valid_q;
    logic [IW-1:0]        winner_q;
    logic [CNT_WIDTH-1:0] latency_q;
    logic                 tie_q;
    logic                 timeout_q;

    logic                 hit_d;
    logic                 multi_d;
    logic [IW-1:0]        idx_d;

    first_one_enc #(
        .N  (N_OUT),
        .IW (IW)
    ) u_enc (
        .vec_i   (neuron_outs),
        .any_o   (hit_d),
        .multi_o (multi_d),
        .idx_o   (idx_d)
    );

    // cnt_q counts clear cycles in CLEAR and RUN cycles in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            neuron_rst_q <= 1'b1;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            winner_q     <= '0;
            latency_q    <= '0;
            tie_q        <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= CLEAR;
                        cnt_q        <= '0;
                        neuron_rst_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt_q == CNT_WIDTH'(CLR_CYCLES - 1)) begin
                        state_q      <= RUN;
                        cnt_q        <= '0;
                        neuron_rst_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    // Detection is tested first so it beats a coincident timeout.
                    if (hit_d) begin
                        state_q   <= DONE;
                        valid_q   <= 1'b1;
                        winner_q  <= idx_d;
                        tie_q     <= multi_d;
                        latency_q <= cnt_q;
                        timeout_q <= 1'b0;
                    end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
                        state_q   <= DONE;
                        valid_q   <= 1'b1;
                        winner_q  <= '0;
                        tie_q     <= 1'b0;
                        latency_q <= CNT_WIDTH'(TIMEOUT);
                        timeout_q <= 1'b1;
                        cnt_q     <= CNT_WIDTH'(TIMEOUT);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    neuron_rst_q <= 1'b1;
                    busy_q       <= 1'b0;
                    valid_q      <= 1'b0;
                end
            endcase
        end
    end

    assign neuron_rst   = neuron_rst_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign winner       = winner_q;
    assign latency      = latency_q;
    assign tie          = tie_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_wta_readout.sv
// Directed bench for wta_readout with an expected-result queue checked on result_valid.
module tb_wta_readout;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  neuron_outs;
    logic        neuron_rst;
    logic        busy;
    logic        result_valid;
    logic        result_ack;
    logic [3:0]  winner;
    logic [11:0] latency;
    logic        tie;
    logic        timeout;

    typedef struct {
        logic [3:0]  winner;
        logic [11:0] latency;
        logic        tie;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;
    int   n_cmp = 0;
    int   n_err = 0;

    wta_readout #(
        .N_OUT      (10),
        .CNT_WIDTH  (12),
        .TIMEOUT    (4000),
        .CLR_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .neuron_outs  (neuron_outs),
        .neuron_rst   (neuron_rst),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .winner       (winner),
        .latency      (latency),
        .tie          (tie),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},    busy,         0);
        chk({tag, "_valid"},   result_valid, 0);
        chk({tag, "_nrst"},    neuron_rst,   1);
        chk({tag, "_winner"},  winner,       0);
        chk({tag, "_latency"}, latency,      0);
        chk({tag, "_tie"},     tie,          0);
        chk({tag, "_timeout"}, timeout,      0);
    endtask

    function automatic exp_t model_hit(input logic [9:0] pat, input int k);
        exp_t e;
        e.winner  = '0;
        for (int i = 9; i >= 0; i--) if (pat[i]) e.winner = 4'(i);
        e.tie     = ($countones(pat) > 1);
        e.latency = 12'(k);
        e.timeout = 1'b0;
        return e;
    endfunction

    // Pops the oldest expectation and compares it to the presented result.
    task automatic check_front(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_nonempty"}, 0, 1);
        end else begin
            e    = exp_q.pop_front();
            held = e;
            chk({tag, "_winner"},  winner,  e.winner);
            chk({tag, "_latency"}, latency, e.latency);
            chk({tag, "_tie"},     tie,     e.tie);
            chk({tag, "_timeout"}, timeout, e.timeout);
        end
    endtask

    // Pulses start and returns just after RUN is entered (counter 0 sampled next edge).
    task automatic start_run(input string tag);
        int low = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1);
        while (!neuron_rst && low < 20) begin
            low++;
            tick();
        end
        chk({tag, "_clear_cycles"}, low, 2);
    endtask

    // Quiet for k RUN cycles, then presents pat for one cycle.
    task automatic do_run(input string tag, input int k, input logic [9:0] pat, input bit poke);
        bit early = 0;
        bit nrst_drop = 0;
        start_run(tag);
        for (int i = 0; i < k; i++) begin
            neuron_outs = '0;
            start = poke && (i % 7 == 3);
            tick();
            if (result_valid) early = 1;
            if (!neuron_rst) nrst_drop = 1;
        end
        start = 1'b0;
        chk({tag, "_no_early_valid"}, early, 0);
        chk({tag, "_nrst_high_in_run"}, nrst_drop, 0);
        neuron_outs = pat;
        exp_q.push_back(model_hit(pat, k));
        tick();
        neuron_outs = '0;
        chk({tag, "_valid_next"}, result_valid, 1);
        check_front(tag);
    endtask

    task automatic do_ack(input string tag, input bit with_start);
        result_ack = 1'b1;
        start = with_start;
        tick();
        result_ack = 1'b0;
        start = 1'b0;
        chk({tag, "_ack_busy"},  busy,         0);
        chk({tag, "_ack_valid"}, result_valid, 0);
        tick();
        tick();
        chk({tag, "_idle_busy"}, busy,       0);
        chk({tag, "_idle_nrst"}, neuron_rst, 1);
    endtask

    initial begin
        int  n;
        bit  changed;
        bit  dropped;
        exp_t e;

        rst = 1'b0; start = 1'b0; neuron_outs = '0; result_ack = 1'b0;
        tick();
        tick();
        chk_reset_outputs("por");
        rst = 1'b1;
        tick();

        // Stray ack in IDLE does nothing.
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("stray_ack_busy", busy, 0);

        do_run("det37", 37, 10'h008, 1'b1);
        do_ack("det37", 1'b0);

        do_run("tie0", 0, 10'h0A0, 1'b0);
        changed = 0;
        dropped = 0;
        for (int i = 0; i < 100; i++) begin
            neuron_outs = 10'($urandom);
            start = (i % 10 == 5);
            tick();
            if (!result_valid) dropped = 1;
            if (winner !== held.winner || latency !== held.latency ||
                tie !== held.tie || timeout !== held.timeout) changed = 1;
        end
        neuron_outs = '0;
        start = 1'b0;
        chk("hold_valid", dropped, 0);
        chk("hold_fields", changed, 0);
        do_ack("tie0", 1'b1);

        start_run("tmo");
        e.winner = 0; e.latency = 12'd4000; e.tie = 0; e.timeout = 1;
        exp_q.push_back(e);
        n = 0;
        while (!result_valid && n < 5000) begin
            tick();
            n++;
        end
        chk("tmo_run_cycles", n, 4000);
        check_front("tmo");
        do_ack("tmo", 1'b0);

        do_run("det_at_tmo", 3999, 10'h001, 1'b0);
        do_ack("det_at_tmo", 1'b0);

        start_run("midrst");
        for (int i = 0; i < 500; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst = 1'b1;
        dropped = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_valid || busy) dropped = 1;
        end
        chk("midrst_stays_idle", dropped, 0);

        do_run("clean", 12, 10'h300, 1'b0);
        do_ack("clean", 1'b0);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wta_readout.md
WTA_READOUT -- requirements
Module: wta_readout

Interface
REQ-001 SHALL have parameter N_OUT, default 10: number of output neurons observed.
REQ-002 SHALL have parameter CNT_WIDTH, default 12: width of the latency counter.
REQ-003 SHALL have parameter TIMEOUT, default 4000: RUN cycle count at which the run is abandoned; must be less than 2**CNT_WIDTH.
REQ-004 SHALL have parameter CLR_CYCLES, default 2: cycles that neuron_rst is held low before RUN.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: request for one classification run.
REQ-008 SHALL have port neuron_outs, input, N_OUT bits: fire flags from the output-neuron array.
REQ-009 SHALL have port neuron_rst, output, 1 bit: active-low reset driven to the output-neuron array.
REQ-010 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 SHALL have port result_valid, output, 1 bit: result fields are stable and valid.
REQ-012 SHALL have port result_ack, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port winner, output, $clog2(N_OUT) bits: index of the winning neuron.
REQ-014 SHALL have port latency, output, CNT_WIDTH bits: RUN cycles elapsed before detection.
REQ-015 SHALL have port tie, output, 1 bit: more than one neuron fired in the detection cycle.
REQ-016 SHALL have port timeout, output, 1 bit: no neuron fired within TIMEOUT cycles.

Function
REQ-017 SHALL implement the FSM states IDLE, CLEAR, RUN and DONE.
REQ-018 SHALL go IDLE->CLEAR on start=1; start in any other state is ignored.
REQ-019 SHALL, in CLEAR, drive neuron_rst=0 for exactly CLR_CYCLES cycles, then go to RUN with the counter at 0.
REQ-020 SHALL drive neuron_rst=1 in every state other than CLEAR.
REQ-021 SHALL, in RUN, sample neuron_outs each cycle; if any bit is 1, go to DONE and register: winner = lowest set index, tie = (popcount > 1), latency = counter, timeout = 0.
REQ-022 SHALL, when RUN has no bit set, increment the counter; when counter = TIMEOUT-1, go to DONE with timeout = 1, winner = 0, tie = 0, latency = TIMEOUT.
REQ-023 SHALL make a detection win when detection and timeout occur in the same cycle.
REQ-024 SHALL assert result_valid exactly in DONE, starting in the cycle after the detection or timeout cycle.
REQ-025 SHALL hold winner, latency, tie and timeout constant while result_valid = 1.
REQ-026 SHALL go DONE->IDLE on result_ack=1; result_ack outside DONE is ignored.
REQ-027 SHALL ignore start=1 presented in the same cycle as the ack; a new run requires start while in IDLE.
REQ-028 SHALL keep the counter saturating: it never wraps and never exceeds TIMEOUT.
REQ-029 SHALL accept an X-free neuron_outs only in RUN; neuron_outs is don't-care in other states.

Reset
REQ-030 SHALL, on rst=0, immediately enter IDLE regardless of state, including mid-CLEAR and mid-RUN.
REQ-031 SHALL reset the outputs to: busy=0, result_valid=0, neuron_rst=1, winner=0, latency=0, tie=0, timeout=0; the counter also resets to 0.
REQ-032 SHALL resume normal operation on the first clk edge after rst deasserts; no partial result from an interrupted run is ever reported.

Structure
REQ-033 SHALL define the state enum (IDLE/CLEAR/RUN/DONE) and the default parameter constants in a shared package, wta_pkg.
REQ-034 SHALL place the combinational lowest-index encoder plus multi-hot detect in one sub-module, first_one_enc, parameterised by N_OUT.
REQ-035 SHALL register all outputs; no combinational path from any input to any output.

Verification (N_OUT=10, CNT_WIDTH=12, TIMEOUT=4000, CLR_CYCLES=2)
REQ-036 SHALL cover: start pulse -> neuron_rst low for exactly 2 cycles, then RUN; neuron_outs=0x008 at RUN cycle 37 -> result_valid next cycle, winner=3, latency=37, tie=0.
REQ-037 SHALL cover: neuron_outs=0x0A0 at RUN cycle 0 -> winner=5, tie=1, latency=0.
REQ-038 SHALL cover: neuron_outs held 0 -> result_valid after 4000 RUN cycles with timeout=1, latency=4000, winner=0.
REQ-039 SHALL cover: result_ack withheld for 100 cycles while neuron_outs toggles randomly -> result fields unchanged; ack -> IDLE, busy=0 next cycle.
REQ-040 SHALL cover: rst pulsed low at RUN cycle 500 -> immediate IDLE with all outputs at reset values; the next start gives a clean run.
REQ-041 SHALL cover: start asserted during RUN and DONE -> no effect; start together with the ack -> FSM stays in IDLE.
